// File: rtl/lc3_mmio_ctrl.sv
// lc3_mmio_ctrl: LC-3 memory/IO controller. MAR/MDR, word-addressed memory
// with a fixed access latency, keyboard (KBSR/KBDR) and display (DSR/DDR)
// device registers, and an optional prioritised interrupt request.
//
// Optional feature macro: LC3_MMIO_INT_EN (registered int_req/int_priority/
// int_vec). Undefined, the interrupt outputs are tied to 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ld_mar, ld_mdr             load MAR / MDR from bus
//   mio_en, r_w                access request (held until ready), 1=write
//   gate_mdr_en                drive MDR onto mdr_out (else high-Z)
//   bus                        processor bus
//   mdr_out, ready             MDR output, one-cycle access-complete strobe
//   kb_valid, kb_data          keyboard strobe and key code
//   ddr_out, ddr_valid         display character and strobe
//   dsp_ack                    display finished the last character
//   int_req, int_priority, int_vec  interrupt request, winning PL and vector
module lc3_mmio_ctrl #(
    parameter int unsigned MEM_AW  = 8,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned KB_PL   = 4,
    parameter int unsigned DSP_PL  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        gate_mdr_en,
    input  logic [15:0] bus,
    output logic [15:0] mdr_out,
    output logic        ready,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic [7:0]  ddr_out,
    output logic        ddr_valid,
    input  logic        dsp_ack,
    output logic        int_req,
    output logic [2:0]  int_priority,
    output logic [7:0]  int_vec
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

    localparam logic [DATA_W-1:0] ADDR_KBSR = 16'hFE00;
    localparam logic [DATA_W-1:0] ADDR_KBDR = 16'hFE02;
    localparam logic [DATA_W-1:0] ADDR_DSR  = 16'hFE04;
    localparam logic [DATA_W-1:0] ADDR_DDR  = 16'hFE06;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mar, mdr;
    logic [DATA_W-1:0] acc_addr;
    logic              acc_rw;
    logic              acc_mem;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic       kb_full, kb_ie, kb_ovr;
    logic [7:0] kbdr;
    logic       dsr_rdy, dsp_ie;

    logic              mar_is_mem;
    logic              done_rd, done_wr;
    logic              sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
    logic [DATA_W-1:0] rd_data;

    assign mar_is_mem = (32'(mar) < MEM_DEPTH);

    // Accesses act on the address latched at start, so MAR may be reloaded freely
    assign done_rd  = (state == S_DONE) && !acc_rw;
    assign done_wr  = (state == S_DONE) &&  acc_rw;
    assign sel_kbsr = (acc_addr == ADDR_KBSR);
    assign sel_kbdr = (acc_addr == ADDR_KBDR);
    assign sel_dsr  = (acc_addr == ADDR_DSR);
    assign sel_ddr  = (acc_addr == ADDR_DDR);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mio_en) state_nxt = mar_is_mem ? S_BUSY : S_DONE;
            S_BUSY: begin
                if (!mio_en)        state_nxt = S_IDLE;
                else if (cnt == '0) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, ready strobe, latency counter and access latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ready    <= 1'b0;
            cnt      <= '0;
            acc_addr <= '0;
            acc_rw   <= 1'b0;
            acc_mem  <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == S_DONE);
            if (state == S_IDLE && mio_en) begin
                acc_addr <= mar;
                acc_rw   <= r_w;
                acc_mem  <= mar_is_mem;
                cnt      <= CNT_W'(MEM_LAT - 1);
            end else if (state == S_BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Read data mux; unmapped addresses read as zero
    always_comb begin
        rd_data = '0;
        if (acc_mem) begin
            rd_data = mem[acc_addr[MEM_AW-1:0]];
        end else if (sel_kbsr) begin
            rd_data = {kb_full, kb_ie, kb_ovr, 13'h0000};
        end else if (sel_kbdr) begin
            rd_data = {8'h00, kbdr};
        end else if (sel_dsr) begin
            rd_data = {dsr_rdy, dsp_ie, 14'h0000};
        end else if (sel_ddr) begin
            rd_data = {8'h00, ddr_out};
        end
    end

    // Memory array, no reset
    always_ff @(posedge clk) begin
        if (done_wr && acc_mem) mem[acc_addr[MEM_AW-1:0]] <= mdr;
    end

    // MAR / MDR; a completing read takes precedence over ld_mdr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (ld_mar) mar <= bus;
            if (done_rd)     mdr <= rd_data;
            else if (ld_mdr) mdr <= bus;
        end
    end

    assign mdr_out = gate_mdr_en ? mdr : 'z;

    // Keyboard; a key arriving with the KBDR read completion refills the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_full <= 1'b0;
            kb_ie   <= 1'b0;
            kb_ovr  <= 1'b0;
            kbdr    <= '0;
        end else begin
            if (done_wr && sel_kbsr) begin
                kb_ie <= mdr[14];
                if (mdr[13]) kb_ovr <= 1'b0;
            end
            if (kb_valid && (!kb_full || (done_rd && sel_kbdr))) begin
                kb_full <= 1'b1;
                kbdr    <= kb_data;
            end else if (kb_valid) begin
                kb_ovr <= 1'b1;
            end else if (done_rd && sel_kbdr) begin
                kb_full <= 1'b0;
            end
        end
    end

    // Display; a DDR write beats a same-cycle dsp_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsr_rdy   <= 1'b1;
            dsp_ie    <= 1'b0;
            ddr_out   <= '0;
            ddr_valid <= 1'b0;
        end else begin
            ddr_valid <= done_wr && sel_ddr;
            if (done_wr && sel_dsr) dsp_ie <= mdr[14];
            if (done_wr && sel_ddr) begin
                dsr_rdy <= 1'b0;
                ddr_out <= mdr[7:0];
            end else if (dsp_ack) begin
                dsr_rdy <= 1'b1;
            end
        end
    end

`ifdef LC3_MMIO_INT_EN
    logic kb_pend, dsp_pend;

    assign kb_pend  = kb_full & kb_ie;
    assign dsp_pend = dsr_rdy & dsp_ie;

    // Higher priority level wins; equal levels go to the keyboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req      <= 1'b0;
            int_priority <= '0;
            int_vec      <= '0;
        end else if (kb_pend && (!dsp_pend || KB_PL >= DSP_PL)) begin
            int_req      <= 1'b1;
            int_priority <= 3'(KB_PL);
            int_vec      <= 8'h80;
        end else if (dsp_pend) begin
            int_req      <= 1'b1;
            int_priority <= 3'(DSP_PL);
            int_vec      <= 8'h81;
        end else begin
            int_req      <= 1'b0;
            int_priority <= '0;
            int_vec      <= '0;
        end
    end
`else
    logic [5:0] unused_pl;

    assign unused_pl    = {3'(KB_PL), 3'(DSP_PL)};
    assign int_req      = 1'b0;
    assign int_priority = '0;
    assign int_vec      = '0;
`endif

endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// Testbench for lc3_mmio_ctrl: directed scenarios plus a randomized access
// mix checked against a behavioural model of memory and device registers.
module tb_lc3_mmio_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0;
    logic        gate_mdr_en = 1'b0;
    logic [15:0] bus = '0;
    logic [15:0] mdr_out;
    logic        ready;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = '0;
    logic [7:0]  ddr_out;
    logic        ddr_valid;
    logic        dsp_ack = 1'b0;
    logic        int_req;
    logic [2:0]  int_priority;
    logic [7:0]  int_vec;

    int n_cmp = 0;
    int n_err = 0;
    int ddr_pulses = 0;

    // Behavioural model
    logic [15:0] m_mem [int];
    bit          m_full, m_ie, m_ovr;
    logic [7:0]  m_kbdr;

    lc3_mmio_ctrl #(.MEM_AW(8), .MEM_LAT(LAT), .KB_PL(4), .DSP_PL(3)) dut (
        .clk(clk), .rst_n(rst_n), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .r_w(r_w), .gate_mdr_en(gate_mdr_en), .bus(bus),
        .mdr_out(mdr_out), .ready(ready), .kb_valid(kb_valid), .kb_data(kb_data),
        .ddr_out(ddr_out), .ddr_valid(ddr_valid), .dsp_ack(dsp_ack),
        .int_req(int_req), .int_priority(int_priority), .int_vec(int_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ddr_valid) ddr_pulses++;

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        m_mem.delete();
        m_full = 0; m_ie = 0; m_ovr = 0; m_kbdr = '0;
    endtask

    // Full CPU-style access; lat = cycles from mio_en to ready (-1 on timeout)
    task automatic access(input logic [15:0] addr, input bit wr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output int lat);
        bus = addr; ld_mar = 1'b1; cyc(); ld_mar = 1'b0;
        if (wr) begin
            bus = wdata; ld_mdr = 1'b1; cyc(); ld_mdr = 1'b0;
        end
        r_w = wr; mio_en = 1'b1; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (ready) begin lat = i; break; end
        end
        mio_en = 1'b0; r_w = 1'b0;
        cyc();
        gate_mdr_en = 1'b1; #1; rdata = mdr_out; gate_mdr_en = 1'b0;
    endtask

    task automatic key(input logic [7:0] d);
        kb_valid = 1'b1; kb_data = d; cyc(); kb_valid = 1'b0;
        if (m_full) m_ovr = 1;
        else begin m_full = 1; m_kbdr = d; end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", ready); end
        n_cmp++; if (ddr_valid !== 1'b0) begin n_err++; $display("FAIL reset_ddr_valid got %b exp 0", ddr_valid); end
        n_cmp++; if (ddr_out !== 8'h00) begin n_err++; $display("FAIL reset_ddr_out got %h exp 00", ddr_out); end
        n_cmp++; if ({int_req, int_priority, int_vec} !== 12'h000) begin n_err++;
            $display("FAIL reset_int got %b/%0d/%h exp 0/0/00", int_req, int_priority, int_vec); end
        gate_mdr_en = 1'b1; #1;
        n_cmp++; if (mdr_out !== 16'h0000) begin n_err++; $display("FAIL reset_mdr got %h exp 0000", mdr_out); end
        gate_mdr_en = 1'b0;
        begin
            logic [15:0] rd; int lat;
            access(16'hFE00, 0, 0, rd, lat);
            n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL reset_kbsr got %h exp 0000", rd); end
            access(16'hFE04, 0, 0, rd, lat);
            n_cmp++; if (rd !== 16'h8000) begin n_err++; $display("FAIL reset_dsr got %h exp 8000", rd); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL reset_reg_lat got %0d exp 1", lat); end
        end
    endtask

    task automatic test_mem();
        logic [15:0] rd; int lat;
        do_reset();
        access(16'h0010, 1, 16'h1234, rd, lat);
        n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL mem_wr_lat got %0d exp %0d", lat, LAT + 1); end
        access(16'h0010, 0, 0, rd, lat);
        n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL mem_rd_lat got %0d exp %0d", lat, LAT + 1); end
        n_cmp++; if (rd !== 16'h1234) begin n_err++; $display("FAIL mem_rd_data got %h exp 1234", rd); end
    endtask

    task automatic test_kb();
        logic [15:0] rd; int lat;
        do_reset();
        key(8'h41);
        access(16'hFE00, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h8000) begin n_err++; $display("FAIL kb_kbsr_full got %h exp 8000", rd); end
        access(16'hFE02, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h0041) begin n_err++; $display("FAIL kb_kbdr got %h exp 0041", rd); end
        access(16'hFE00, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL kb_kbsr_clear got %h exp 0000", rd); end
    endtask

    task automatic test_kb_overrun();
        logic [15:0] rd; int lat;
        do_reset();
        key(8'h41);
        cyc();
        key(8'h42);
        access(16'hFE02, 1, 16'h00FF, rd, lat);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL ovr_kbdr_wr_lat got %0d exp 1", lat); end
        access(16'hFE00, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'hA000) begin n_err++; $display("FAIL ovr_kbsr got %h exp A000", rd); end
        access(16'hFE00, 1, 16'h2000, rd, lat);
        access(16'hFE00, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h8000) begin n_err++; $display("FAIL ovr_w1c got %h exp 8000", rd); end
        access(16'hFE02, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h0041) begin n_err++; $display("FAIL ovr_kbdr_kept got %h exp 0041", rd); end
    endtask

    // Key strobe coincides with the KBDR read completion
    task automatic test_kbdr_race();
        logic [15:0] rd; int lat;
        do_reset();
        key(8'h41);
        bus = 16'hFE02; ld_mar = 1'b1; cyc(); ld_mar = 1'b0;
        r_w = 1'b0; mio_en = 1'b1; cyc();
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL race_ready got %b exp 1", ready); end
        mio_en = 1'b0; kb_valid = 1'b1; kb_data = 8'h42; cyc(); kb_valid = 1'b0;
        gate_mdr_en = 1'b1; #1; rd = mdr_out; gate_mdr_en = 1'b0;
        n_cmp++; if (rd !== 16'h0041) begin n_err++; $display("FAIL race_old_key got %h exp 0041", rd); end
        access(16'hFE00, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h8000) begin n_err++; $display("FAIL race_kbsr got %h exp 8000", rd); end
        access(16'hFE02, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h0042) begin n_err++; $display("FAIL race_new_key got %h exp 0042", rd); end
    endtask

    task automatic test_display();
        logic [15:0] rd; int lat;
        do_reset();
        ddr_pulses = 0;
        access(16'hFE06, 1, 16'h0058, rd, lat);
        cyc(3);
        n_cmp++; if (ddr_pulses !== 1) begin n_err++; $display("FAIL dsp_pulses got %0d exp 1", ddr_pulses); end
        n_cmp++; if (ddr_out !== 8'h58) begin n_err++; $display("FAIL dsp_ddr_out got %h exp 58", ddr_out); end
        access(16'hFE04, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL dsp_dsr_busy got %h exp 0000", rd); end
        dsp_ack = 1'b1; cyc(); dsp_ack = 1'b0;
        access(16'hFE04, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h8000) begin n_err++; $display("FAIL dsp_dsr_ack got %h exp 8000", rd); end
    endtask

    task automatic test_abort();
        logic [15:0] rd; int lat; int seen;
        do_reset();
        access(16'h0020, 1, 16'hBEEF, rd, lat);
        bus = 16'h0020; ld_mar = 1'b1; cyc(); ld_mar = 1'b0;
        bus = 16'h5555; ld_mdr = 1'b1; cyc(); ld_mdr = 1'b0;
        r_w = 1'b1; mio_en = 1'b1; seen = 0;
        cyc(); if (ready) seen++;
        mio_en = 1'b0; r_w = 1'b0;
        for (int i = 0; i < 5; i++) begin cyc(); if (ready) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_ready got %0d strobes exp 0", seen); end
        access(16'h0020, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'hBEEF) begin n_err++; $display("FAIL abort_mem got %h exp BEEF", rd); end
        access(16'h3000, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'h0000) begin n_err++; $display("FAIL unmapped_rd got %h exp 0000", rd); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL unmapped_lat got %0d exp 1", lat); end
    endtask

    task automatic test_int();
        logic [15:0] rd; int lat;
        logic [11:0] exp_dsp, exp_kb;
`ifdef LC3_MMIO_INT_EN
        exp_dsp = {1'b1, 3'd3, 8'h81};
        exp_kb  = {1'b1, 3'd4, 8'h80};
`else
        exp_dsp = 12'h000;
        exp_kb  = 12'h000;
`endif
        do_reset();
        access(16'hFE04, 1, 16'h4000, rd, lat);
        cyc(2);
        n_cmp++; if ({int_req, int_priority, int_vec} !== exp_dsp) begin n_err++;
            $display("FAIL int_dsp got %h exp %h", {int_req, int_priority, int_vec}, exp_dsp); end
        access(16'hFE00, 1, 16'h4000, rd, lat);
        key(8'h33);
        cyc(2);
        n_cmp++; if ({int_req, int_priority, int_vec} !== exp_kb) begin n_err++;
            $display("FAIL int_both got %h exp %h", {int_req, int_priority, int_vec}, exp_kb); end
        access(16'hFE00, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'hC000) begin n_err++; $display("FAIL int_kbsr_ie got %h exp C000", rd); end
        access(16'hFE04, 0, 0, rd, lat);
        n_cmp++; if (rd !== 16'hC000) begin n_err++; $display("FAIL int_dsr_ie got %h exp C000", rd); end
    endtask

    task automatic test_random();
        logic [15:0] rd, a, d, e; int lat, el;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: begin
                    a = 16'($urandom_range(0, 255)); d = 16'($urandom);
                    access(a, 1, d, rd, lat);
                    m_mem[int'(a)] = d;
                    n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL rnd_wr_lat @%h got %0d exp %0d", a, lat, LAT + 1); end
                end
                1: begin
                    a = 16'($urandom_range(0, 255));
                    access(a, 0, 0, rd, lat);
                    n_cmp++; if (lat !== LAT + 1) begin n_err++; $display("FAIL rnd_rd_lat @%h got %0d exp %0d", a, lat, LAT + 1); end
                    if (m_mem.exists(int'(a))) begin
                        e = m_mem[int'(a)];
                        n_cmp++; if (rd !== e) begin n_err++; $display("FAIL rnd_rd @%h got %h exp %h", a, rd, e); end
                    end
                end
                2: begin
                    a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h0100, 16'hFDFF))
                                                    : 16'($urandom_range(16'hFE08, 16'hFFFF));
                    access(a, 0, 0, rd, lat);
                    el = 1;
                    n_cmp++; if (rd !== 16'h0000 || lat !== el) begin n_err++;
                        $display("FAIL rnd_unmapped @%h got %h/%0d exp 0000/%0d", a, rd, lat, el); end
                end
                3: key(8'($urandom));
                4: begin
                    access(16'hFE00, 0, 0, rd, lat);
                    e = {m_full, m_ie, m_ovr, 13'h0};
                    n_cmp++; if (rd !== e) begin n_err++; $display("FAIL rnd_kbsr got %h exp %h", rd, e); end
                end
                5: begin
                    access(16'hFE02, 0, 0, rd, lat);
                    e = {8'h00, m_kbdr};
                    m_full = 0;
                    n_cmp++; if (rd !== e) begin n_err++; $display("FAIL rnd_kbdr got %h exp %h", rd, e); end
                end
                default: begin
                    d = 16'($urandom);
                    access(16'hFE00, 1, d, rd, lat);
                    m_ie = d[14];
                    if (d[13]) m_ovr = 0;
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_mem();
        test_kb();
        test_kb_overrun();
        test_kbdr_race();
        test_display();
        test_abort();
        test_int();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lc3_mmio_ctrl.md
LC3_MMIO_CTRL -- requirements
Module: lc3_mmio_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, 8, memory address width in 16-bit words (depth 2**MEM_AW, 1..12).
REQ-002 SHALL have parameter MEM_LAT, 2, memory access latency in cycles (1..15).
REQ-003 SHALL have parameter KB_PL, 4, keyboard interrupt priority level (0..7).
REQ-004 SHALL have parameter DSP_PL, 3, display interrupt priority level (0..7).
REQ-005 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-007 SHALL have ports: ld_mar in 1 load MAR from bus; ld_mdr in 1 load MDR; mio_en in 1 memory/IO cycle request; r_w in 1 (1 write, 0 read); gate_mdr_en in 1 drive MDR onto mdr_out.
REQ-008 SHALL have ports: bus in 16 processor bus; mdr_out out 16 MDR, high-Z when gate_mdr_en=0; ready out 1 cycle-complete strobe.
REQ-009 SHALL have ports: kb_valid in 1 key strobe; kb_data in 8 key code; ddr_out out 8 display char; ddr_valid out 1 char strobe; dsp_ack in 1 display done.
REQ-010 SHALL have ports: int_req out 1 interrupt request; int_priority out 3 winning PL; int_vec out 8 winning vector.

Function
REQ-011 SHALL decode MAR: FE00 KBSR, FE02 KBDR, FE04 DSR, FE06 DDR; MAR < 2**MEM_AW memory (word-addressed, index MAR[MEM_AW-1:0]); everything else unmapped.
REQ-012 SHALL run FSM IDLE/BUSY/DONE: IDLE + mio_en -> BUSY for memory (count MEM_LAT cycles) or -> DONE directly for registers/unmapped; BUSY -> DONE at count end; DONE -> IDLE.
REQ-013 SHALL assert ready only in DONE (one cycle); mio_en must stay high until ready.
REQ-014 SHALL abort BUSY -> IDLE without ready and without any write if mio_en drops mid-access.
REQ-015 SHALL, on read in DONE, load MDR with selected data (unmapped reads 0); this load overrides a simultaneous ld_mdr.
REQ-016 SHALL, with ld_mdr and no completing read, load MDR from bus; ld_mar loads MAR from bus at any time, captured value used only from next IDLE.
REQ-017 SHALL commit writes in DONE from MDR; unmapped writes dropped but ready still given; KBDR writes ignored.
REQ-018 SHALL set KBSR[15] and KBDR[7:0]=kb_data on kb_valid when KBSR[15]=0; clear KBSR[15] on KBDR read completion.
REQ-019 SHALL, on kb_valid with KBSR[15]=1, drop the key, keep KBDR, set sticky KBSR[13]; KBSR write clears [13] if MDR[13]=1 (W1C), writes [14] IE.
REQ-020 SHALL give kb_valid priority over a same-cycle KBDR read clear (key captured, [15] stays 1).
REQ-021 SHALL, on DDR write, clear DSR[15], drive ddr_out=MDR[7:0], pulse ddr_valid one cycle; dsp_ack sets DSR[15]; same-cycle DDR write wins. DSR write affects only [14] IE.
REQ-022 SHALL read KBSR/DSR with unused bits 0, KBDR upper byte 0.

Reset
REQ-023 SHALL on rst_n=0 set FSM IDLE, MAR=0, MDR=0, KBSR=0, KBDR=0, DSR=0x8000, ddr_out=0, ddr_valid=0, ready=0, int_req=0, int_priority=0, int_vec=0; memory contents undefined.
REQ-024 SHALL abort any in-flight access on reset with no write.

Configuration
REQ-025 SHALL with LC3_MMIO_INT_EN defined register int_req/int_priority/int_vec (1-cycle latency): kb pending=KBSR[15]&KBSR[14] (vec 0x80, KB_PL), dsp pending=DSR[15]&DSR[14] (vec 0x81, DSP_PL); higher PL wins, tie -> keyboard.
REQ-026 SHALL without LC3_MMIO_INT_EN tie int_req, int_priority, int_vec to 0; IE bits remain read/writable.

Verification
REQ-027 SHALL cover: MEM_LAT=2, write 0x1234 to 0x0010 then read -> ready 3 cycles after mio_en each, MDR=0x1234.
REQ-028 SHALL cover: kb_valid data 0x41, read KBSR then KBDR -> 0x8000, 0x0041, then KBSR=0x0000.
REQ-029 SHALL cover: two kb_valid (0x41,0x42) with no read -> KBDR=0x0041, KBSR=0xA000; write KBSR 0x2000 -> 0x8000.
REQ-030 SHALL cover: write DDR 0x0058 -> ddr_valid 1 cycle, ddr_out=0x58, DSR=0x0000; dsp_ack -> DSR=0x8000.
REQ-031 SHALL cover: INT_EN, KBSR IE=1, DSR IE=1, both pending -> int_req=1, int_priority=4, int_vec=0x80.
REQ-032 SHALL cover: write to 0x0020 with mio_en dropped in BUSY -> no ready, later read of 0x0020 returns prior value; read of 0x3000 -> MDR=0.
